// File: rtl/mem_wb_pipe_pkg.sv
// Shared definitions for the MEM/WB pipeline stage: default widths,
// write-enable encodings, the hard-wired zero register index and the
// stage-action decode used by the stage register.
package mem_wb_pipe_pkg;

    localparam int DEF_RADDR_W   = 5;
    localparam int DEF_RDATA_W   = 32;
    localparam int DEF_CSR_AW    = 12;
    localparam int DEF_CSR_DW    = 32;
    localparam int DEF_STALL_W   = 6;
    localparam int DEF_STALL_IDX = 4;
    localparam int DEF_PC_W      = 32;

    localparam int   ZERO_REG      = 0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    typedef enum logic [1:0] {
        STAGE_ADVANCE = 2'd0,
        STAGE_HOLD    = 2'd1,
        STAGE_BUBBLE  = 2'd2,
        STAGE_FLUSH   = 2'd3
    } stage_act_e;

    // Flush beats any stall; a stalled stage holds only when the stage
    // below is also stalled, otherwise it must hand a bubble downstream.
    function automatic stage_act_e stage_action(input logic flush,
                                                input logic stall_here,
                                                input logic stall_next);
        stage_act_e act;
        if (flush) begin
            act = STAGE_FLUSH;
        end else if (stall_here && stall_next) begin
            act = STAGE_HOLD;
        end else if (stall_here) begin
            act = STAGE_BUBBLE;
        end else begin
            act = STAGE_ADVANCE;
        end
        return act;
    endfunction

endpackage

// File: rtl/mem_wb_pipe_retire_counter.sv
// Retired-instruction counter with a split half-word software write port.
// A software write always wins over the increment in the same cycle, and a
// low-half write never carries into the high half.
module retire_counter
    import mem_wb_pipe_pkg::*;
#(
    parameter int HALF_W = DEF_CSR_DW
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  incr_i,
    input  logic [1:0]            we_i,
    input  logic [HALF_W-1:0]     wdata_i,
    output logic [2*HALF_W-1:0]   count_o
);

    localparam int CNT_W = 2 * HALF_W;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: half writes replace their half, otherwise count retires.
    always_comb begin
        count_d = count_q;
        if (we_i != 2'b00) begin
            if (we_i[0] == WRITE_ENABLE) begin
                count_d[HALF_W-1:0] = wdata_i;
            end
            if (we_i[1] == WRITE_ENABLE) begin
                count_d[CNT_W-1:HALF_W] = wdata_i;
            end
        end else if (incr_i) begin
            count_d = count_q + CNT_ONE;
        end
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage register. Captures the instruction leaving MEM,
// suppresses writes to x0, handles flush/bubble/hold, and produces a single
// retire pulse per captured instruction that drives the instret counter.
module mem_wb_pipe
    import mem_wb_pipe_pkg::*;
#(
    parameter int RADDR_W   = DEF_RADDR_W,
    parameter int RDATA_W   = DEF_RDATA_W,
    parameter int CSR_AW    = DEF_CSR_AW,
    parameter int CSR_DW    = DEF_CSR_DW,
    parameter int STALL_W   = DEF_STALL_W,
    parameter int STALL_IDX = DEF_STALL_IDX,
    parameter int PC_W      = DEF_PC_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [STALL_W-1:0]    stall_i,
    input  logic                  flush_int_i,
    input  logic                  valid_i,
    input  logic [PC_W-1:0]       pc_i,
    input  logic                  reg_we_i,
    input  logic [RADDR_W-1:0]    reg_waddr_i,
    input  logic [RDATA_W-1:0]    reg_wdata_i,
    input  logic                  csr_we_i,
    input  logic [CSR_AW-1:0]     csr_waddr_i,
    input  logic [CSR_DW-1:0]     csr_wdata_i,
    input  logic [1:0]            instret_we_i,
    input  logic [CSR_DW-1:0]     instret_wdata_i,
    output logic                  valid_o,
    output logic [PC_W-1:0]       pc_o,
    output logic                  reg_we_o,
    output logic [RADDR_W-1:0]    reg_waddr_o,
    output logic [RDATA_W-1:0]    reg_wdata_o,
    output logic                  csr_we_o,
    output logic [CSR_AW-1:0]     csr_waddr_o,
    output logic [CSR_DW-1:0]     csr_wdata_o,
    output logic                  instret_incr_o,
    output logic [2*CSR_DW-1:0]   instret_o
);

    localparam logic [RADDR_W-1:0] ZERO_ADDR = RADDR_W'(ZERO_REG);

    stage_act_e stage_act;

    logic                 valid_q,        valid_d;
    logic [PC_W-1:0]      pc_q,           pc_d;
    logic                 reg_we_q,       reg_we_d;
    logic [RADDR_W-1:0]   reg_waddr_q,    reg_waddr_d;
    logic [RDATA_W-1:0]   reg_wdata_q,    reg_wdata_d;
    logic                 csr_we_q,       csr_we_d;
    logic [CSR_AW-1:0]    csr_waddr_q,    csr_waddr_d;
    logic [CSR_DW-1:0]    csr_wdata_q,    csr_wdata_d;
    logic                 instret_incr_q, instret_incr_d;

    // Only the two stall bits around this stage matter; the rest of the
    // vector belongs to other stages.
    logic unused_stall_bits;
    assign unused_stall_bits = ^stall_i;

    // Decide what the stage register does this cycle, then form its next value.
    always_comb begin
        stage_act      = stage_action(flush_int_i, stall_i[STALL_IDX], stall_i[STALL_IDX+1]);
        valid_d        = valid_q;
        pc_d           = pc_q;
        reg_we_d       = reg_we_q;
        reg_waddr_d    = reg_waddr_q;
        reg_wdata_d    = reg_wdata_q;
        csr_we_d       = csr_we_q;
        csr_waddr_d    = csr_waddr_q;
        csr_wdata_d    = csr_wdata_q;
        instret_incr_d = 1'b0;
        case (stage_act)
            STAGE_ADVANCE: begin
                valid_d        = valid_i;
                pc_d           = pc_i;
                reg_we_d       = reg_we_i & valid_i & (reg_waddr_i != ZERO_ADDR);
                reg_waddr_d    = reg_waddr_i;
                reg_wdata_d    = reg_wdata_i;
                csr_we_d       = csr_we_i & valid_i;
                csr_waddr_d    = csr_waddr_i;
                csr_wdata_d    = csr_wdata_i;
                instret_incr_d = valid_i;
            end
            STAGE_HOLD: begin
                instret_incr_d = 1'b0;
            end
            default: begin
                valid_d     = 1'b0;
                pc_d        = '0;
                reg_we_d    = WRITE_DISABLE;
                reg_waddr_d = '0;
                reg_wdata_d = '0;
                csr_we_d    = WRITE_DISABLE;
                csr_waddr_d = '0;
                csr_wdata_d = '0;
            end
        endcase
    end

    // Stage register, cleared asynchronously so a held instruction is lost on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q        <= 1'b0;
            pc_q           <= '0;
            reg_we_q       <= WRITE_DISABLE;
            reg_waddr_q    <= '0;
            reg_wdata_q    <= '0;
            csr_we_q       <= WRITE_DISABLE;
            csr_waddr_q    <= '0;
            csr_wdata_q    <= '0;
            instret_incr_q <= 1'b0;
        end else begin
            valid_q        <= valid_d;
            pc_q           <= pc_d;
            reg_we_q       <= reg_we_d;
            reg_waddr_q    <= reg_waddr_d;
            reg_wdata_q    <= reg_wdata_d;
            csr_we_q       <= csr_we_d;
            csr_waddr_q    <= csr_waddr_d;
            csr_wdata_q    <= csr_wdata_d;
            instret_incr_q <= instret_incr_d;
        end
    end

    // The counter advances on the same edge that raises the retire pulse,
    // so instret_o already includes the instruction the pulse announces.
    retire_counter #(
        .HALF_W (CSR_DW)
    ) u_retire_counter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .incr_i  (instret_incr_d),
        .we_i    (instret_we_i),
        .wdata_i (instret_wdata_i),
        .count_o (instret_o)
    );

    assign valid_o        = valid_q;
    assign pc_o           = pc_q;
    assign reg_we_o       = reg_we_q;
    assign reg_waddr_o    = reg_waddr_q;
    assign reg_wdata_o    = reg_wdata_q;
    assign csr_we_o       = csr_we_q;
    assign csr_waddr_o    = csr_waddr_q;
    assign csr_wdata_o    = csr_wdata_q;
    assign instret_incr_o = instret_incr_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Testbench for mem_wb_pipe: directed scenarios followed by randomized
// traffic, all checked against a behavioural model of the WB stage.
module tb_mem_wb_pipe;

    localparam int RADDR_W   = 5;
    localparam int RDATA_W   = 32;
    localparam int CSR_AW    = 12;
    localparam int CSR_DW    = 32;
    localparam int STALL_W   = 6;
    localparam int STALL_IDX = 4;
    localparam int PC_W      = 32;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic [STALL_W-1:0]   stall_i;
    logic                 flush_int_i;
    logic                 valid_i;
    logic [PC_W-1:0]      pc_i;
    logic                 reg_we_i;
    logic [RADDR_W-1:0]   reg_waddr_i;
    logic [RDATA_W-1:0]   reg_wdata_i;
    logic                 csr_we_i;
    logic [CSR_AW-1:0]    csr_waddr_i;
    logic [CSR_DW-1:0]    csr_wdata_i;
    logic [1:0]           instret_we_i;
    logic [CSR_DW-1:0]    instret_wdata_i;
    logic                 valid_o;
    logic [PC_W-1:0]      pc_o;
    logic                 reg_we_o;
    logic [RADDR_W-1:0]   reg_waddr_o;
    logic [RDATA_W-1:0]   reg_wdata_o;
    logic                 csr_we_o;
    logic [CSR_AW-1:0]    csr_waddr_o;
    logic [CSR_DW-1:0]    csr_wdata_o;
    logic                 instret_incr_o;
    logic [2*CSR_DW-1:0]  instret_o;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: what the WB stage should be showing.
    logic                 m_valid;
    logic [PC_W-1:0]      m_pc;
    logic                 m_reg_we;
    logic [RADDR_W-1:0]   m_reg_waddr;
    logic [RDATA_W-1:0]   m_reg_wdata;
    logic                 m_csr_we;
    logic [CSR_AW-1:0]    m_csr_waddr;
    logic [CSR_DW-1:0]    m_csr_wdata;
    logic                 m_incr;
    logic [63:0]          m_count;

    mem_wb_pipe #(
        .RADDR_W   (RADDR_W),
        .RDATA_W   (RDATA_W),
        .CSR_AW    (CSR_AW),
        .CSR_DW    (CSR_DW),
        .STALL_W   (STALL_W),
        .STALL_IDX (STALL_IDX),
        .PC_W      (PC_W)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .stall_i         (stall_i),
        .flush_int_i     (flush_int_i),
        .valid_i         (valid_i),
        .pc_i            (pc_i),
        .reg_we_i        (reg_we_i),
        .reg_waddr_i     (reg_waddr_i),
        .reg_wdata_i     (reg_wdata_i),
        .csr_we_i        (csr_we_i),
        .csr_waddr_i     (csr_waddr_i),
        .csr_wdata_i     (csr_wdata_i),
        .instret_we_i    (instret_we_i),
        .instret_wdata_i (instret_wdata_i),
        .valid_o         (valid_o),
        .pc_o            (pc_o),
        .reg_we_o        (reg_we_o),
        .reg_waddr_o     (reg_waddr_o),
        .reg_wdata_o     (reg_wdata_o),
        .csr_we_o        (csr_we_o),
        .csr_waddr_o     (csr_waddr_o),
        .csr_wdata_o     (csr_wdata_o),
        .instret_incr_o  (instret_incr_o),
        .instret_o       (instret_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkField(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkField({tag, ".valid"},     64'(valid_o),        64'(m_valid));
        checkField({tag, ".pc"},        64'(pc_o),           64'(m_pc));
        checkField({tag, ".reg_we"},    64'(reg_we_o),       64'(m_reg_we));
        checkField({tag, ".reg_waddr"}, 64'(reg_waddr_o),    64'(m_reg_waddr));
        checkField({tag, ".reg_wdata"}, 64'(reg_wdata_o),    64'(m_reg_wdata));
        checkField({tag, ".csr_we"},    64'(csr_we_o),       64'(m_csr_we));
        checkField({tag, ".csr_waddr"}, 64'(csr_waddr_o),    64'(m_csr_waddr));
        checkField({tag, ".csr_wdata"}, 64'(csr_wdata_o),    64'(m_csr_wdata));
        checkField({tag, ".incr"},      64'(instret_incr_o), 64'(m_incr));
        checkField({tag, ".instret"},   instret_o,           m_count);
    endtask

    task automatic modelClearStage();
        m_valid = 1'b0; m_pc = '0; m_reg_we = 1'b0; m_reg_waddr = '0; m_reg_wdata = '0;
        m_csr_we = 1'b0; m_csr_waddr = '0; m_csr_wdata = '0; m_incr = 1'b0;
    endtask

    // Evaluate what the next clock edge should do given the current inputs.
    task automatic modelStep();
        bit retire;
        retire = 1'b0;
        if (flush_int_i) begin
            modelClearStage();
        end else if (stall_i[STALL_IDX] && !stall_i[STALL_IDX+1]) begin
            modelClearStage();
        end else if (stall_i[STALL_IDX]) begin
            m_incr = 1'b0;
        end else begin
            m_valid     = valid_i;
            m_pc        = pc_i;
            m_reg_we    = reg_we_i && valid_i && (reg_waddr_i != 0);
            m_reg_waddr = reg_waddr_i;
            m_reg_wdata = reg_wdata_i;
            m_csr_we    = csr_we_i && valid_i;
            m_csr_waddr = csr_waddr_i;
            m_csr_wdata = csr_wdata_i;
            m_incr      = valid_i;
            retire      = valid_i;
        end
        if (instret_we_i != 2'b00) begin
            if (instret_we_i[0]) m_count[31:0]  = instret_wdata_i;
            if (instret_we_i[1]) m_count[63:32] = instret_wdata_i;
        end else if (retire) begin
            m_count = m_count + 64'd1;
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] pc,
                                 input logic rwe, input logic [4:0] ra, input logic [31:0] rd,
                                 input logic cwe, input logic [11:0] ca, input logic [31:0] cd,
                                 input logic [5:0] stall, input logic flush,
                                 input logic [1:0] iwe, input logic [31:0] iwd);
        valid_i = v; pc_i = pc; reg_we_i = rwe; reg_waddr_i = ra; reg_wdata_i = rd;
        csr_we_i = cwe; csr_waddr_i = ca; csr_wdata_i = cd;
        stall_i = stall; flush_int_i = flush; instret_we_i = iwe; instret_wdata_i = iwd;
        modelStep();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        valid_i = 0; pc_i = 0; reg_we_i = 0; reg_waddr_i = 0; reg_wdata_i = 0;
        csr_we_i = 0; csr_waddr_i = 0; csr_wdata_i = 0;
        stall_i = 0; flush_int_i = 0; instret_we_i = 0; instret_wdata_i = 0;
        modelClearStage();
        m_count = 64'd0;
        $display("[TB] starting mem_wb_pipe test");

        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("reset");
        rst_i = 1'b0;

        // Basic advance of a GPR write.
        applyStimulus(1, 32'h100, 1, 5, 32'hDEADBEEF, 0, 0, 0, 6'b000000, 0, 2'b00, 0);
        checkOutput("advance");
        checkField("advance.we_const",   64'(reg_we_o), 64'd1);
        checkField("advance.wdata_const", 64'(reg_wdata_o), 64'hDEADBEEF);
        checkField("advance.cnt_const",  instret_o, 64'd1);

        // Write to x0 is suppressed, then the stage holds for three cycles.
        applyStimulus(1, 32'h104, 1, 0, 32'h1234, 1, 12'h300, 32'hAA, 6'b000000, 0, 2'b00, 0);
        checkOutput("x0");
        checkField("x0.we_const", 64'(reg_we_o), 64'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 32'h200 + i, 1, 7, 32'h5555 + i, 1, 12'h7, 32'h9, 6'b110000, 0, 2'b00, 0);
            checkOutput("hold");
            checkField("hold.incr_const", 64'(instret_incr_o), 64'd0);
            checkField("hold.pc_const",   64'(pc_o), 64'h104);
        end

        // Bubble, then flush while stalled.
        applyStimulus(1, 32'h300, 1, 9, 32'h77, 1, 12'h1, 32'h2, 6'b010000, 0, 2'b00, 0);
        checkOutput("bubble");
        checkField("bubble.valid_const", 64'(valid_o), 64'd0);
        applyStimulus(1, 32'h304, 1, 10, 32'h88, 1, 12'h2, 32'h3, 6'b000000, 0, 2'b00, 0);
        checkOutput("pre_flush");
        applyStimulus(1, 32'h308, 1, 11, 32'h99, 1, 12'h3, 32'h4, 6'b110000, 1, 2'b00, 0);
        checkOutput("flush");
        checkField("flush.csr_we_const", 64'(csr_we_o), 64'd0);

        // Counter preload, wrap of the low half, and write/retire collision.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 2'b10, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 2'b01, 32'hFFFFFFFF);
        checkOutput("preload");
        applyStimulus(1, 32'h400, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 2'b00, 0);
        checkOutput("wrap");
        checkField("wrap.cnt_const", instret_o, 64'h1_0000_0000);
        applyStimulus(1, 32'h404, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 2'b01, 32'd7);
        checkOutput("collide");
        checkField("collide.cnt_const", instret_o, 64'h1_0000_0007);

        // Asynchronous reset while holding, then a fresh capture.
        applyStimulus(1, 32'h500, 1, 3, 32'hCAFE, 0, 0, 0, 6'b000000, 0, 2'b00, 0);
        applyStimulus(1, 32'h504, 1, 4, 32'hF00D, 0, 0, 0, 6'b110000, 0, 2'b00, 0);
        checkOutput("pre_rst_hold");
        #3;
        rst_i = 1'b1;
        #1;
        modelClearStage();
        m_count = 64'd0;
        checkOutput("async_rst");
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        applyStimulus(1, 32'h600, 1, 12, 32'h0BADF00D, 1, 12'h341, 32'h11, 6'b000000, 0, 2'b00, 0);
        checkOutput("post_rst");
        checkField("post_rst.cnt_const", instret_o, 64'd1);
        checkField("post_rst.pc_const",  64'(pc_o), 64'h600);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [5:0]  st;
            logic [1:0]  iw;
            logic [4:0]  ra;
            int unsigned sel;
            sel = $urandom_range(0, 7);
            st  = 6'($urandom_range(0, 15));
            if (sel == 5)      st[5:4] = 2'b01;
            else if (sel >= 6) st[5:4] = 2'b11;
            else               st[5:4] = {1'($urandom_range(0, 1)), 1'b0};
            iw = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            ra = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            applyStimulus(1'($urandom), $urandom, 1'($urandom), ra, $urandom,
                          1'($urandom), 12'($urandom), $urandom, st,
                          ($urandom_range(0, 15) == 0), iw,
                          ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom);
            checkOutput("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
